// File: rtl/multicycle_ctrl_fsm_pkg.sv
// rtl/multicycle_ctrl_fsm_pkg.sv - shared state, opcode and select encodings for the multicycle control FSM
package ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_FETCH  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_MEMADR = 4'd3;
    localparam state_t S_MEMRD  = 4'd4;
    localparam state_t S_MEMWB  = 4'd5;
    localparam state_t S_MEMWR  = 4'd6;
    localparam state_t S_EXEC_R = 4'd7;
    localparam state_t S_EXEC_I = 4'd8;
    localparam state_t S_ALUWB  = 4'd9;
    localparam state_t S_BRANCH = 4'd10;
    localparam state_t S_TRAP   = 4'd11;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // States that hold a request on the shared memory port and are watched for stalls.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - control/datapath signal bundle for the multicycle control FSM
interface multicycle_ctrl_fsm_if #(parameter int CNT_W = 32);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       result_src;
    logic             instr_done;
    logic [CNT_W-1:0] retired_cnt;
    logic             mem_timeout;
    logic             trap;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src,
               instr_done, retired_cnt, mem_timeout, trap
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src,
               instr_done, retired_cnt, mem_timeout, trap
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_watchdog.sv
// rtl/multicycle_ctrl_fsm_mem_wait_watchdog.sv - stall counter and timeout compare for memory states
module mem_wait_watchdog #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_ready,
    input  logic i_clear,
    output logic o_expire
);
    localparam int W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [W-1:0] LAST_WAIT = W'(MEM_WAIT_MAX - 1);

    logic [W-1:0] r_cnt;

    // Fires on the stall cycle that would bring the count to MEM_WAIT_MAX; a ready in that cycle completes instead.
    assign o_expire = i_active && !i_ready && (r_cnt == LAST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_expire) begin
            r_cnt <= '0;
        end else if (i_active && !i_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle RV32-subset control FSM; define ILLEGAL_TRAP_EN for the illegal-opcode trap
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_ctrl_fsm_if.master  bus
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired_cnt;
    logic             r_mem_timeout;
    logic             w_expire;
    logic             w_state_change;

    logic       w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write, w_reg_write, w_instr_done;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src;

    assign w_state_change = (w_next != r_state);

    mem_wait_watchdog #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_active (is_mem_state(r_state)),
        .i_ready  (bus.mem_ready),
        .i_clear  (w_state_change),
        .o_expire (w_expire)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:           w_next = S_TRAP;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: w_next = (bus.opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.mem_ready)  w_next = S_MEMWB;
                else if (w_expire)  w_next = S_FETCH;
            end
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (bus.mem_ready || w_expire) w_next = S_FETCH;
            S_EXEC_R: w_next = S_ALUWB;
            S_EXEC_I: w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
    end

    // Moore decode; only the FETCH/MEMWR completion strobes and the BRANCH pc_write look at inputs.
    always_comb begin
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        w_result_src = RES_ALUOUT;
        case (r_state)
            S_FETCH: begin
                w_mem_read   = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALU;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_result_src = RES_MEMDATA;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write  = 1'b1;
                w_iord       = 1'b1;
                w_instr_done = bus.mem_ready;
            end
            S_EXEC_R: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_op     = ALUOP_SUB;
                w_pc_write   = bus.zero;
                w_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_retired_cnt <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_instr_done) r_retired_cnt <= r_retired_cnt + 1'b1;
            if (w_expire)     r_mem_timeout <= 1'b1;
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.ir_write    = w_ir_write;
    assign bus.iord        = w_iord;
    assign bus.mem_read    = w_mem_read;
    assign bus.mem_write   = w_mem_write;
    assign bus.reg_write   = w_reg_write;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.alu_op      = w_alu_op;
    assign bus.result_src  = w_result_src;
    assign bus.instr_done  = w_instr_done;
    assign bus.retired_cnt = r_retired_cnt;
    assign bus.mem_timeout = r_mem_timeout;
`ifdef ILLEGAL_TRAP_EN
    assign bus.trap        = (r_state == S_TRAP);
`else
    assign bus.trap        = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - self-checking bench: vector table, directed corner cases, randomized instruction stream
module tb_multicycle_ctrl_fsm;
    import ctrl_pkg::*;

    localparam int MAX = 15;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.CNT_W(CW)) bus ();
    multicycle_ctrl_fsm #(.MEM_WAIT_MAX(MAX), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One instruction: stimulus plus expected per-instruction totals.
    typedef struct {
        logic [6:0] op;
        logic       z;
        int         fw;
        int         dw;
        int         cyc;
        int         mr;
        int         mw;
        int         irw;
        int         pcw;
        int         rw;
        int         wb;
        int         done;
        int         to;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int exp_retired = 0;
    logic exp_to = 1'b0;

    logic [6:0] s_en;
    logic [7:0] s_sel;
    int s_mr, s_mw, s_irw, s_pcw, s_rw, s_wb, s_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample();
        s_en  = {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write, bus.reg_write, bus.instr_done};
        s_sel = {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src};
    endtask

    // Called just after a falling edge: drive mem_ready, sample, accumulate, advance to next falling edge.
    task automatic cyc(input logic rdy);
        bus.mem_ready = rdy;
        #1;
        sample();
        s_mr   += int'(bus.mem_read);
        s_mw   += int'(bus.mem_write);
        s_irw  += int'(bus.ir_write);
        s_pcw  += int'(bus.pc_write);
        s_rw   += int'(bus.reg_write);
        s_wb   += int'(bus.reg_write && bus.result_src == 2'b01);
        s_done += int'(bus.instr_done);
        @(negedge clk);
    endtask

    task automatic clear_stats();
        s_mr = 0; s_mw = 0; s_irw = 0; s_pcw = 0; s_rw = 0; s_wb = 0; s_done = 0;
    endtask

    // Reference: instruction cost from phase lengths (fetch, decode, class work, data access, writeback).
    function automatic vec_t model(input logic [6:0] op, input logic z, input int fw, input int dw);
        vec_t v;
        v = '{op, z, fw, dw, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        if (fw >= MAX) begin
            v.cyc = MAX; v.mr = MAX; v.to = 1;
            return v;
        end
        v.cyc = fw + 2; v.mr = fw + 1; v.irw = 1; v.pcw = 1;
        if (op == OP_R || op == OP_I) begin
            v.cyc += 2; v.rw = 1; v.done = 1;
        end else if (op == OP_BRANCH) begin
            v.cyc += 1; v.pcw += int'(z); v.done = 1;
        end else if (op == OP_LOAD) begin
            v.cyc += 1;
            if (dw >= MAX) begin
                v.cyc += MAX; v.mr += MAX; v.to = 1;
            end else begin
                v.cyc += dw + 2; v.mr += dw + 1; v.rw = 1; v.wb = 1; v.done = 1;
            end
        end else if (op == OP_STORE) begin
            v.cyc += 1;
            if (dw >= MAX) begin
                v.cyc += MAX; v.mw = MAX; v.to = 1;
            end else begin
                v.cyc += dw + 1; v.mw = dw + 1; v.done = 1;
            end
        end
        return v;
    endfunction

    // mem_ready schedule: 0 = low, 1 = high, 2 = no request outstanding (driven randomly).
    function automatic int ready_at(input vec_t v, input int k);
        int flen, ds, dlen;
        flen = (v.fw >= MAX) ? MAX : v.fw + 1;
        if (k < flen) return (v.fw < MAX && k == v.fw) ? 1 : 0;
        if (v.op == OP_LOAD || v.op == OP_STORE) begin
            ds   = flen + 2;
            dlen = (v.dw >= MAX) ? MAX : v.dw + 1;
            if (k >= ds && k < ds + dlen) return (v.dw < MAX && (k - ds) == v.dw) ? 1 : 0;
        end
        return 2;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int code;
        bus.opcode = v.op;
        bus.zero   = v.z;
        clear_stats();
        for (int k = 0; k < v.cyc; k++) begin
            code = ready_at(v, k);
            cyc((code == 2) ? 1'($urandom_range(0, 1)) : 1'(code));
        end
        exp_retired += v.done;
        if (v.to != 0) exp_to = 1'b1;
        chk({tag, ".mem_read_cycles"},  s_mr,   v.mr);
        chk({tag, ".mem_write_cycles"}, s_mw,   v.mw);
        chk({tag, ".ir_write"},         s_irw,  v.irw);
        chk({tag, ".pc_write"},         s_pcw,  v.pcw);
        chk({tag, ".reg_write"},        s_rw,   v.rw);
        chk({tag, ".mem_writeback"},    s_wb,   v.wb);
        chk({tag, ".instr_done"},       s_done, v.done);
        chk({tag, ".retired_cnt"},      bus.retired_cnt, exp_retired);
        chk({tag, ".mem_timeout"},      bus.mem_timeout, exp_to);
        chk({tag, ".trap"},             bus.trap, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b1;
        #1;
        sample();
        chk({tag, ".rst_enables"}, s_en, 7'b0);
        chk({tag, ".rst_selects"}, s_sel, 8'b0);
        chk({tag, ".rst_retired"}, bus.retired_cnt, 0);
        chk({tag, ".rst_timeout"}, bus.mem_timeout, 1'b0);
        chk({tag, ".rst_trap"},    bus.trap, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1);
        chk({tag, ".idle_enables"}, s_en, 7'b0);
        chk({tag, ".idle_selects"}, s_sel, 8'b0);
        exp_retired = 0;
        exp_to = 1'b0;
    endtask

    vec_t       tbl[$];
    logic [6:0] r_en[4]  = '{7'b1101000, 7'b0000000, 7'b0000000, 7'b0000011};
    logic [7:0] r_sel[4] = '{8'b00100010, 8'b01010000, 8'b10001000, 8'b00000000};

    initial begin
        logic [6:0] op;
        logic       z;
        int         fw, dw, pick;

        bus.opcode = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        do_reset("reset0");

        // R-type cycle by cycle: FETCH, DECODE, EXEC_R, ALUWB.
        bus.opcode = OP_R;
        bus.zero = 1'b0;
        chk("rtype.retired_before", bus.retired_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            cyc((k == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
            chk($sformatf("rtype.c%0d.enables", k), s_en, r_en[k]);
            chk($sformatf("rtype.c%0d.selects", k), s_sel, r_sel[k]);
        end
        chk("rtype.retired_after", bus.retired_cnt, 1);
        exp_retired = 1;

        tbl.push_back('{OP_R,      1'b0, 0,  0,  4,  1,  0, 1, 1, 1, 0, 1, 0});
        tbl.push_back('{OP_LOAD,   1'b0, 0,  3,  8,  5,  0, 1, 1, 1, 1, 1, 0});
        tbl.push_back('{OP_BRANCH, 1'b1, 0,  0,  3,  1,  0, 1, 2, 0, 0, 1, 0});
        tbl.push_back('{OP_BRANCH, 1'b0, 0,  0,  3,  1,  0, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{OP_I,      1'b0, 2,  0,  6,  3,  0, 1, 1, 1, 0, 1, 0});
        tbl.push_back('{OP_STORE,  1'b0, 0,  0,  4,  1,  1, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{OP_STORE,  1'b0, 0,  99, 18, 1,  15, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{OP_LOAD,   1'b0, 1,  14, 20, 17, 0, 1, 1, 1, 1, 1, 0});
        tbl.push_back('{OP_R,      1'b0, 99, 0,  15, 15, 0, 0, 0, 0, 0, 0, 1});
        tbl.push_back('{OP_LOAD,   1'b0, 0,  15, 18, 16, 0, 1, 1, 0, 0, 0, 1});
`ifndef ILLEGAL_TRAP_EN
        tbl.push_back('{7'b0000000, 1'b0, 0, 0,  2,  1,  0, 1, 1, 0, 0, 0, 0});
`endif
        tbl.push_back('{OP_R,      1'b0, 1,  0,  5,  2,  0, 1, 1, 1, 0, 1, 0});
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while MEMRD is stalled: outputs drop at once, counters clear.
        bus.opcode = OP_LOAD;
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        bus.mem_ready = 1'b0;
        #1;
        chk("rstmid.memrd_active", bus.mem_read && bus.iord, 1'b1);
        do_reset("rstmid");
        cyc(1'b0);
        chk("rstmid.fetch_enables", s_en, 7'b0001000);
        chk("rstmid.retired", bus.retired_cnt, 0);

`ifdef ILLEGAL_TRAP_EN
        do_reset("trap_pre");
        bus.opcode = 7'b0000000;
        cyc(1'b1);
        cyc(1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'($urandom_range(0, 1)));
            chk($sformatf("trap.c%0d.enables", k), s_en, 7'b0);
            chk($sformatf("trap.c%0d.selects", k), s_sel, 8'b0);
            chk($sformatf("trap.c%0d.flag", k), bus.trap, 1'b1);
        end
        do_reset("trap_post");
`endif

        do_reset("rnd_pre");
        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 5);
            case (pick)
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LOAD;
                3: op = OP_STORE;
                4: op = OP_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                default: op = OP_LOAD;
`else
                default: op = 7'($urandom_range(0, 127)) & 7'b0001100;
`endif
            endcase
            z  = 1'($urandom_range(0, 1));
            fw = ($urandom_range(0, 9) == 0) ? MAX + $urandom_range(0, 3) : $urandom_range(0, 3);
            case ($urandom_range(0, 7))
                0:       dw = MAX - 1;
                1:       dw = MAX + $urandom_range(0, 2);
                default: dw = $urandom_range(0, 4);
            endcase
            run_vec(model(op, z, fw, dw), $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
